// File: rtl/mips_mem_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared definitions for the MIPS memory controller slice:
//            FSM state encoding, data word width and request op codes.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t WAIT   = 2'd1;
  localparam state_t ACCESS = 2'd2;
  localparam state_t DONE   = 2'd3;

  // Latched operation; a write wins when both strobes are high.
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mips_mem_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_mem_if
// Purpose  : Core-to-memory request/response bundle. The core is the master
//            (address, store data, strobes); the controller is the slave
//            (read data, ready pulse, busy, alignment error).
// Revision : 1.0 - initial release
// ============================================================================
interface mips_mem_if;
  import mips_mem_pkg::*;

  logic [WORD_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_busy;
  logic              cpu_err;

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  cpu_rdata, cpu_ready, cpu_busy, cpu_err
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output cpu_rdata, cpu_ready, cpu_busy, cpu_err
  );

endinterface : mips_mem_if
`default_nettype wire

// File: rtl/mips_mem_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_mem_array
// Purpose  : Synchronous single-port RAM backing the MIPS memory controller.
//            Registered read every cycle, write when we_i is high. Contents
//            are never reset.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter     INIT_FILE = ""
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] idx_i,
  input  wire logic [WORD_W-1:0] wdata_i,
  output logic      [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Single port: write on we_i, read the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule : mips_mem_array
`default_nettype wire

// File: rtl/mips_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_mem_ctrl
// Purpose  : Word-addressed memory controller for the multicycle MIPS core.
//            Latches a request in IDLE, inserts WAIT_CYCLES wait states,
//            performs the array access and pulses cpu_ready for one cycle.
// Config   : MIPS_MEM_ALIGN_CHK_EN - when defined, misaligned addresses skip
//            the array access and raise cpu_err with cpu_ready.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input wire logic  clk,
  input wire logic  reset,
  mips_mem_if.slave mem_if
);

  // Counter preload; with no wait states the counter is never consulted.
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              op_q;
  logic              mis_q;

  logic              req;
  logic              mis_in;
  logic              busy, ready, err;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_idx;
  logic [WORD_W-1:0] arr_rdata;

  assign req = mem_if.cpu_rd | mem_if.cpu_wr;

`ifdef MIPS_MEM_ALIGN_CHK_EN
  assign mis_in = |mem_if.cpu_addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // Byte-lane bits and bits above the word index do not select a word.
  logic unused_addr;
  assign unused_addr = ^{mem_if.cpu_addr[WORD_W-1:ADDR_W+2], mem_if.cpu_addr[1:0]};

  // State register and wait counter; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE -> WAIT -> ACCESS -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and array controls decoded from the current state.
  always_comb begin
    busy    = (state_q != IDLE);
    ready   = (state_q == DONE);
    err     = (state_q == DONE) & mis_q;
    arr_we  = (state_q == ACCESS) & (op_q == OP_WR) & ~mis_q;
    // Present the incoming index in IDLE so a zero-wait access has the
    // array word ready by the time ACCESS registers it.
    arr_idx = (state_q == IDLE) ? mem_if.cpu_addr[ADDR_W+1:2] : idx_q;
  end

  // Request latches and the registered read-data output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if ((state_q == IDLE) && req) begin
        idx_q   <= mem_if.cpu_addr[ADDR_W+1:2];
        wdata_q <= mem_if.cpu_wdata;
        op_q    <= mem_if.cpu_wr ? OP_WR : OP_RD;
        mis_q   <= mis_in;
      end
      if ((state_q == ACCESS) && (op_q == OP_RD) && !mis_q) begin
        rdata_q <= arr_rdata;
      end
    end
  end

  mips_mem_array #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .idx_i   (arr_idx),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign mem_if.cpu_rdata = rdata_q;
  assign mem_if.cpu_ready = ready;
  assign mem_if.cpu_busy  = busy;
  assign mem_if.cpu_err   = err;

endmodule : mips_mem_ctrl
`default_nettype wire

// File: tb/tb_mips_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mips_mem_ctrl
// Purpose  : Self-checking bench for mips_mem_ctrl: directed scenarios plus
//            randomized traffic against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mem_ctrl;
  import mips_mem_pkg::*;

  localparam int DEPTH       = 256;
  localparam int ADDR_W      = 8;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mips_mem_if bus ();

  mips_mem_ctrl #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES),
    .INIT_FILE   ("")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array, written-flags, last read value.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_vld [DEPTH];
  logic [31:0] ref_rdata;
  int          written[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_access(input bit rd, input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wdata,
                                     output logic [31:0] exp_rdata, output bit exp_err);
    int idx;
    bit mis;
    idx = int'((addr / 4) % DEPTH);
    mis = 1'b0;
`ifdef MIPS_MEM_ALIGN_CHK_EN
    mis = (addr % 4) != 0;
`endif
    exp_err = mis;
    if (!mis) begin
      if (wr) begin
        ref_mem[idx] = wdata;
        if (!ref_vld[idx]) written.push_back(idx);
        ref_vld[idx] = 1'b1;
      end else if (rd) begin
        ref_rdata = ref_mem[idx];
      end
    end
    exp_rdata = ref_rdata;
  endfunction

  // One complete access: drive, watch busy/latency, check results, release.
  task automatic do_access(input string tag, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          lat;
    ref_access(rd, wr, addr, wdata, exp_rdata, exp_err);
    @(negedge clk);
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    lat = -1;
    for (int k = 0; k < WAIT_CYCLES + 10; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        lat = k;
        break;
      end
      check({tag, "_busy"}, 32'(bus.cpu_busy), 32'd1);
    end
    if (lat < 0) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
      check({tag, "_busy_done"}, 32'(bus.cpu_busy), 32'd1);
      check({tag, "_err"}, 32'(bus.cpu_err), 32'(exp_err));
      check({tag, "_rdata"}, bus.cpu_rdata, exp_rdata);
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    @(negedge clk);
    check({tag, "_ready_off"}, 32'(bus.cpu_ready), 32'd0);
    check({tag, "_busy_off"}, 32'(bus.cpu_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
    ref_rdata     = 32'd0;
    reset         = 1'b1;
    bus.cpu_addr  = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_busy",  32'(bus.cpu_busy),  32'd0);
    check("rst_err",   32'(bus.cpu_err),   32'd0);
    check("rst_rdata", bus.cpu_rdata,      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic write/read, and rdata holding across a later write.
    do_access("wr40", 1'b0, 1'b1, 32'h40, 32'h12345678);
    do_access("rd40", 1'b1, 1'b0, 32'h40, 32'h0);
    do_access("wr44", 1'b0, 1'b1, 32'h44, 32'h0BADCAFE);
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.cpu_rdata, 32'h12345678);

    // Both strobes: write wins, read data untouched.
    do_access("rdwr80", 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5);
    do_access("rd80",   1'b1, 1'b0, 32'h80, 32'h0);

    // Reset during WAIT of a write discards it.
    do_access("wr10", 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
    @(negedge clk);
    bus.cpu_addr  = 32'h10;
    bus.cpu_wdata = 32'hDEADBEEF;
    bus.cpu_wr    = 1'b1;
    @(negedge clk);
    check("abort_busy_wait", 32'(bus.cpu_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.cpu_busy), 32'd0);
    check("abort_rdata", bus.cpu_rdata, 32'd0);
    bus.cpu_wr = 1'b0;
    ref_rdata  = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < WAIT_CYCLES + 4; k++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(bus.cpu_ready), 32'd0);
    end
    do_access("rd10", 1'b1, 1'b0, 32'h10, 32'h0);

    // Index wraps modulo DEPTH.
    do_access("wr400", 1'b0, 1'b1, 32'h400, 32'h600DF00D);
    do_access("rd000", 1'b1, 1'b0, 32'h000, 32'h0);

    // Misaligned write; outcome depends on the alignment-check build.
    do_access("wr42", 1'b0, 1'b1, 32'h42, 32'h77777777);
    do_access("rd40b", 1'b1, 1'b0, 32'h40, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 120; n++) begin
      int          op;
      int          idx;
      logic [31:0] addr;
      logic [31:0] wd;
      op = int'($urandom_range(0, 3));
      wd = $urandom;
      if (op == 1 || op == 3) begin
        idx  = written[$urandom_range(0, written.size() - 1)];
        addr = ($urandom & ~32'h3FC) | (32'(idx) << 2);
      end else begin
        addr = $urandom;
      end
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      case (op)
        0:       do_access("rnd_wr",   1'b0, 1'b1, addr, wd);
        2:       do_access("rnd_rdwr", 1'b1, 1'b1, addr, wd);
        default: do_access("rnd_rd",   1'b1, 1'b0, addr, wd);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mips_mem_ctrl
`default_nettype wire
